// File: rtl/bcd_calc_core.sv
// N-digit BCD calculator engine: key-driven operand entry, digit-serial add/subtract,
// two's-complement-style negate of a borrowed-out result, and result chaining.
module bcd_calc_core #(
    parameter int DIGITS = 4,
    parameter int KEY_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [KEY_W-1:0]      key_i,
    input  logic                  key_valid_i,
    output logic [4*DIGITS-1:0]   disp_o,
    output logic                  neg_o,
    output logic                  ovf_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            stage_o
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS) + 1;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        CALC,
        NEGATE,
        RESULT
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     a, a_nxt;
    logic [W-1:0]     b, b_nxt;
    logic [W-1:0]     r, r_nxt;
    logic             op, op_nxt;
    logic             carry, carry_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             b_entered, b_entered_nxt;
    logic             neg, neg_nxt;
    logic             ovf, ovf_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;

    logic       is_digit, is_add, is_sub, is_eq, is_clr, is_bs;
    logic [3:0] key_dig;

    always_comb begin
        is_digit = key_valid_i && (key_i < KEY_W'(10));
        is_add   = key_valid_i && (key_i == KEY_W'(10));
        is_sub   = key_valid_i && (key_i == KEY_W'(11));
        is_eq    = key_valid_i && (key_i == KEY_W'(12));
        is_clr   = key_valid_i && (key_i == KEY_W'(13));
        is_bs    = key_valid_i && (key_i == KEY_W'(14));
        key_dig  = key_i[3:0];
    end

    logic [3:0] sel_a, sel_b, sel_r;
    logic [3:0] dig_x, dig_y, dig_res;
    logic       dig_c, sub_mode, last;
    logic [4:0] sum5, diff5, adj;

    // NEGATE reuses the subtract rule with a zero minuend and R as subtrahend.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i)) begin
                sel_a = a[4*i +: 4];
                sel_b = b[4*i +: 4];
                sel_r = r[4*i +: 4];
            end
        end
        sub_mode = (state == NEGATE) || op;
        dig_x    = (state == NEGATE) ? 4'd0 : sel_a;
        dig_y    = (state == NEGATE) ? sel_r : sel_b;
        sum5     = {1'b0, dig_x} + {1'b0, dig_y} + {4'b0, carry};
        diff5    = {1'b0, dig_x} - {1'b0, dig_y} - {4'b0, carry};
        adj      = '0;
        if (sub_mode) begin
            dig_c = diff5[4];
            adj   = diff5 + 5'd10;
            dig_res = dig_c ? adj[3:0] : diff5[3:0];
        end else begin
            dig_c = (sum5 > 5'd9);
            adj   = sum5 - 5'd10;
            dig_res = dig_c ? adj[3:0] : sum5[3:0];
        end
        last = (cnt == CNT_W'(DIGITS - 1));
    end

    always_comb begin
        state_nxt     = state;
        a_nxt         = a;
        b_nxt         = b;
        r_nxt         = r;
        op_nxt        = op;
        carry_nxt     = carry;
        cnt_nxt       = cnt;
        b_entered_nxt = b_entered;
        neg_nxt       = neg;
        ovf_nxt       = ovf;

        if (is_clr) begin
            state_nxt     = ENTER_A;
            a_nxt         = '0;
            b_nxt         = '0;
            r_nxt         = '0;
            op_nxt        = 1'b0;
            carry_nxt     = 1'b0;
            cnt_nxt       = '0;
            b_entered_nxt = 1'b0;
            neg_nxt       = 1'b0;
            ovf_nxt       = 1'b0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_digit) begin
                        a_nxt = {a[W-5:0], key_dig};
                    end else if (is_bs) begin
                        a_nxt = {4'b0, a[W-1:4]};
                    end else if (is_add || is_sub) begin
                        op_nxt        = is_sub;
                        b_nxt         = '0;
                        b_entered_nxt = 1'b0;
                        state_nxt     = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        b_nxt         = {b[W-5:0], key_dig};
                        b_entered_nxt = 1'b1;
                    end else if (is_bs) begin
                        b_nxt = {4'b0, b[W-1:4]};
                    end else if ((is_add || is_sub) && !b_entered) begin
                        op_nxt = is_sub;
                    end else if (is_eq) begin
                        cnt_nxt   = '0;
                        carry_nxt = 1'b0;
                        state_nxt = CALC;
                    end
                end
                CALC, NEGATE: begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (cnt == CNT_W'(i)) r_nxt[4*i +: 4] = dig_res;
                    end
                    carry_nxt = dig_c;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (last) begin
                        if (state == NEGATE) begin
                            neg_nxt   = 1'b1;
                            ovf_nxt   = 1'b0;
                            state_nxt = RESULT;
                        end else if (!op) begin
                            ovf_nxt   = dig_c;
                            neg_nxt   = 1'b0;
                            state_nxt = RESULT;
                        end else if (!dig_c) begin
                            neg_nxt   = 1'b0;
                            ovf_nxt   = 1'b0;
                            state_nxt = RESULT;
                        end else begin
                            cnt_nxt   = '0;
                            carry_nxt = 1'b0;
                            state_nxt = NEGATE;
                        end
                    end
                end
                RESULT: begin
                    if (is_digit) begin
                        a_nxt     = {{(W-4){1'b0}}, key_dig};
                        b_nxt     = '0;
                        neg_nxt   = 1'b0;
                        ovf_nxt   = 1'b0;
                        state_nxt = ENTER_A;
                    end else if ((is_add || is_sub) && !neg && !ovf) begin
                        a_nxt         = r;
                        b_nxt         = '0;
                        op_nxt        = is_sub;
                        b_entered_nxt = 1'b0;
                        state_nxt     = ENTER_B;
                    end
                end
                default: state_nxt = ENTER_A;
            endcase
        end

        busy_nxt = (state_nxt == CALC) || (state_nxt == NEGATE);
        done_nxt = (state_nxt == RESULT) && (state != RESULT);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ENTER_A;
            a         <= '0;
            b         <= '0;
            r         <= '0;
            op        <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            b_entered <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            r         <= r_nxt;
            op        <= op_nxt;
            carry     <= carry_nxt;
            cnt       <= cnt_nxt;
            b_entered <= b_entered_nxt;
            neg       <= neg_nxt;
            ovf       <= ovf_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // neg/ovf are only ever set on entry to RESULT and cleared on every exit path.
    always_comb begin
        neg_o  = neg;
        ovf_o  = ovf;
        busy_o = busy;
        done_o = done;
        case (state)
            ENTER_A: begin disp_o = a; stage_o = 2'd0; end
            ENTER_B: begin disp_o = b; stage_o = 2'd1; end
            RESULT:  begin disp_o = r; stage_o = 2'd2; end
            default: begin disp_o = b; stage_o = 2'd3; end
        endcase
    end

endmodule

// File: tb/tb_bcd_calc_core.sv
// Directed, table-driven bench for bcd_calc_core (DIGITS=4) plus hand-written multi-cycle sequences.
module tb_bcd_calc_core;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  key_i = 4'hF;
    logic        key_valid_i = 1'b0;
    logic [15:0] disp_o;
    logic        neg_o, ovf_o, busy_o, done_o;
    logic [1:0]  stage_o;

    always #5 clk_i = ~clk_i;

    bcd_calc_core #(.DIGITS(4), .KEY_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .key_i       (key_i),
        .key_valid_i (key_valid_i),
        .disp_o      (disp_o),
        .neg_o       (neg_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .stage_o     (stage_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk_i);
        key_i = k;
        key_valid_i = 1'b1;
        @(negedge clk_i);
        key_valid_i = 1'b0;
        key_i = 4'hF;
    endtask

    // cyc counts the edge that sampled equals as 1; -1 means done never arrived.
    task automatic wait_done(output int cyc);
        bit found;
        found = 1'b0;
        cyc = 1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (done_o) found = 1'b1;
        end
        if (!found) cyc = -1;
    endtask

    task automatic press_seq(input logic [47:0] keys, input int n);
        for (int j = 0; j < n; j++) press(keys[(n-1-j)*4 +: 4]);
    endtask

    typedef struct {
        logic [47:0] keys;
        int          n;
        logic [15:0] disp;
        logic        neg;
        logic        ovf;
        logic [1:0]  stage;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic seen;

        vecs[0]  = '{48'h1234A566C,  9, 16'h1800, 1'b0, 1'b0, 2'd2, 5};
        vecs[1]  = '{48'h12B30C,     6, 16'h0018, 1'b1, 1'b0, 2'd2, 9};
        vecs[2]  = '{48'h99B99C,     6, 16'h0000, 1'b0, 1'b0, 2'd2, 5};
        vecs[3]  = '{48'h9999A1C,    7, 16'h0000, 1'b0, 1'b1, 2'd2, 5};
        vecs[4]  = '{48'h12345EAB1C, 10, 16'h0233, 1'b0, 1'b0, 2'd2, 5};
        vecs[5]  = '{48'h5A5C,       4, 16'h0010, 1'b0, 1'b0, 2'd2, 5};
        vecs[6]  = '{48'h1234,       4, 16'h1234, 1'b0, 1'b0, 2'd0, 0};
        vecs[7]  = '{48'h7A3BC,      5, 16'h0010, 1'b0, 1'b0, 2'd2, 5};
        vecs[8]  = '{48'h5CC,        3, 16'h0005, 1'b0, 1'b0, 2'd0, 0};
        vecs[9]  = '{48'h4F2,        3, 16'h0042, 1'b0, 1'b0, 2'd0, 0};
        vecs[10] = '{48'h0001B0002C, 10, 16'h0001, 1'b1, 1'b0, 2'd2, 9};
        vecs[11] = '{48'h5000B0001C, 10, 16'h4999, 1'b0, 1'b0, 2'd2, 5};
        vecs[12] = '{48'h23B23C,     6, 16'h0000, 1'b0, 1'b0, 2'd2, 5};
        vecs[13] = '{48'h9999A9999C, 10, 16'h9998, 1'b0, 1'b1, 2'd2, 5};
        vecs[14] = '{48'h8A42EC,     6, 16'h0012, 1'b0, 1'b0, 2'd2, 5};
        vecs[15] = '{48'h123456,     6, 16'h3456, 1'b0, 1'b0, 2'd0, 0};
        vecs[16] = '{48'h3A5EBC,     6, 16'h0003, 1'b0, 1'b0, 2'd2, 5};

        // reset state
        #12;
        chk("rst_disp",  disp_o,  0);
        chk("rst_stage", stage_o, 0);
        chk("rst_flags", {neg_o, ovf_o, busy_o, done_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 17; i++) begin
            press(4'd13);
            if (vecs[i].lat != 0) begin
                press_seq(vecs[i].keys >> 4, vecs[i].n - 1);
                press(vecs[i].keys[3:0]);
                chk($sformatf("v%0d_busy", i), {busy_o, stage_o}, {1'b1, 2'd3});
                wait_done(cyc);
                chk($sformatf("v%0d_lat", i), cyc, vecs[i].lat);
            end else begin
                press_seq(vecs[i].keys, vecs[i].n);
            end
            chk($sformatf("v%0d_disp", i),  disp_o,  vecs[i].disp);
            chk($sformatf("v%0d_neg", i),   neg_o,   vecs[i].neg);
            chk($sformatf("v%0d_ovf", i),   ovf_o,   vecs[i].ovf);
            chk($sformatf("v%0d_stage", i), stage_o, vecs[i].stage);
        end

        // done is a single-cycle pulse; add after overflow is ignored
        press(4'd13);
        press_seq(48'h9999A1, 6);
        press(4'd12);
        wait_done(cyc);
        @(posedge clk_i); #1;
        chk("done_pulse", done_o, 0);
        press(4'd10);
        chk("ovf_chain_stage", stage_o, 2);
        chk("ovf_chain_disp",  {ovf_o, disp_o}, {1'b1, 16'h0000});

        // chaining, and RESULT ignoring backspace/equals
        press(4'd13);
        press_seq(48'h5A5, 3);
        press(4'd12);
        wait_done(cyc);
        press(4'd14);
        chk("res_bs_disp", disp_o, 16'h0010);
        press(4'd12);
        chk("res_eq_done", {done_o, stage_o}, {1'b0, 2'd2});
        press(4'd10);
        chk("chain_b", {stage_o, disp_o}, {2'd1, 16'h0000});
        press(4'd2);
        press(4'd12);
        wait_done(cyc);
        chk("chain_lat", cyc, 5);
        chk("chain_disp", disp_o, 16'h0012);
        press(4'd7);
        chk("chain_new", {stage_o, disp_o}, {2'd0, 16'h0007});

        // negative result blocks chaining; digit leaves RESULT and drops neg
        press(4'd13);
        press_seq(48'h12B30C, 6);
        wait_done(cyc);
        press(4'd11);
        chk("neg_chain_stage", {stage_o, neg_o}, {2'd2, 1'b1});
        press(4'd3);
        chk("neg_exit", {stage_o, neg_o, disp_o}, {2'd0, 1'b0, 16'h0003});

        // clear two clocks after equals aborts with no done
        press(4'd13);
        press_seq(48'h1A2C, 4);
        press(4'd13);
        chk("clr_mid", {stage_o, busy_o, disp_o}, {2'd0, 1'b0, 16'h0000});
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk_i); #1;
            seen = seen | done_o;
        end
        chk("clr_no_done", seen, 0);

        // non-clear keys during busy are dropped
        press(4'd13);
        press_seq(48'h1A2C, 4);
        press(4'd5);
        chk("busy_key_disp", {stage_o, disp_o}, {2'd3, 16'h0002});
        wait_done(cyc);
        chk("busy_key_res", {stage_o, disp_o}, {2'd2, 16'h0003});

        // async reset mid-NEGATE
        press(4'd13);
        press_seq(48'h1B2C, 4);
        repeat (6) @(posedge clk_i);
        #1;
        chk("in_negate", {busy_o, stage_o, disp_o}, {1'b1, 2'd3, 16'h0002});
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("arst_out", {disp_o, stage_o, neg_o, ovf_o, busy_o, done_o}, 22'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        press(4'd6);
        chk("arst_after", {stage_o, disp_o}, {2'd0, 16'h0006});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
